// File: rtl/stopwatch_core.sv
// stopwatch_core
// MM:SS stopwatch that counts up or down in BCD and offers an adjust mode for
// loading individual digits.
//
// Parameters
//   TICK_DIV      clk_c cycles per count step (1..65536)
//   MIN_TENS_MAX  upper limit of the minutes tens digit (1..9)
//
// Ports
//   clk_c      in   system clock, rising edge
//   reset_c    in   asynchronous active-high reset
//   pause_c    in   start/pause request (debounced); only its rising edge acts
//   adj        in   level, 1 = adjust mode
//   sel[1:0]   in   digit select in adjust mode (0 sec ones .. 3 min tens)
//   num[3:0]   in   value loaded into the selected digit (clamped)
//   load       in   write strobe, honoured only in adjust mode
//   dir        in   0 = count up, 1 = count down
//   sec_ones, sec_tens, min_ones, min_tens [3:0]  out  registered BCD digits
//   running    out  1 while counting
//   wrap       out  one-cycle pulse on an up-count rollover to 00:00
//   done       out  sticky flag, set when a down count reaches 00:00
module stopwatch_core #(
    parameter int TICK_DIV     = 1,
    parameter int MIN_TENS_MAX = 5
) (
    input  logic       clk_c,
    input  logic       reset_c,
    input  logic       pause_c,
    input  logic       adj,
    input  logic [1:0] sel,
    input  logic [3:0] num,
    input  logic       load,
    input  logic       dir,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap,
    output logic       done
);

    localparam logic [15:0] PRE_LAST = 16'(TICK_DIV - 1);
    localparam logic [3:0]  MT_MAX   = 4'(MIN_TENS_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ADJ  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic        pause_q;
    logic [15:0] presc;
    logic        pe;
    logic        step;
    logic        is_zero;
    logic        at_max;
    logic        down_to_zero;
    logic [3:0]  so_nx;
    logic [3:0]  st_nx;
    logic [3:0]  mo_nx;
    logic [3:0]  mt_nx;
    logic        done_nx;
    logic        wrap_nx;

    assign pe      = pause_c & ~pause_q;
    // A pending adjust request freezes the count, so a step that would land
    // in the same cycle as adj is dropped.
    assign step    = (state == RUN) && (presc == PRE_LAST) && !adj;
    assign is_zero = (sec_ones == 4'd0) && (sec_tens == 4'd0) &&
                     (min_ones == 4'd0) && (min_tens == 4'd0);
    assign at_max  = (sec_ones == 4'd9) && (sec_tens == 4'd5) &&
                     (min_ones == 4'd9) && (min_tens == MT_MAX);
    // A down step from 00:01 lands on zero; a down step while already at
    // zero (dir flipped mid-run) holds there and also counts as reaching it.
    assign down_to_zero = is_zero ||
                          ((sec_ones == 4'd1) && (sec_tens == 4'd0) &&
                           (min_ones == 4'd0) && (min_tens == 4'd0));

    // Next-state, next-digit and flag logic.
    always_comb begin
        state_nx = state;
        so_nx    = sec_ones;
        st_nx    = sec_tens;
        mo_nx    = min_ones;
        mt_nx    = min_tens;
        done_nx  = done;
        wrap_nx  = 1'b0;

        if (step) begin
            if (!dir) begin
                wrap_nx = at_max;
                if (sec_ones == 4'd9) begin
                    so_nx = 4'd0;
                    if (sec_tens == 4'd5) begin
                        st_nx = 4'd0;
                        if (min_ones == 4'd9) begin
                            mo_nx = 4'd0;
                            mt_nx = (min_tens == MT_MAX) ? 4'd0 : min_tens + 4'd1;
                        end else begin
                            mo_nx = min_ones + 4'd1;
                        end
                    end else begin
                        st_nx = sec_tens + 4'd1;
                    end
                end else begin
                    so_nx = sec_ones + 4'd1;
                end
            end else if (!is_zero) begin
                if (sec_ones == 4'd0) begin
                    so_nx = 4'd9;
                    if (sec_tens == 4'd0) begin
                        st_nx = 4'd5;
                        if (min_ones == 4'd0) begin
                            mo_nx = 4'd9;
                            mt_nx = min_tens - 4'd1;
                        end else begin
                            mo_nx = min_ones - 4'd1;
                        end
                    end else begin
                        st_nx = sec_tens - 4'd1;
                    end
                end else begin
                    so_nx = sec_ones - 4'd1;
                end
            end
        end

        if (adj) begin
            state_nx = ADJ;
        end else begin
            case (state)
                ADJ: state_nx = IDLE;
                IDLE: begin
                    if (pe && !(dir && is_zero)) begin
                        state_nx = RUN;
                        done_nx  = 1'b0;
                    end
                end
                RUN: begin
                    if (step && dir && down_to_zero) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end
                    if (pe) begin
                        state_nx = IDLE;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end

        if ((state == ADJ) && load) begin
            done_nx = 1'b0;
            case (sel)
                2'd0: so_nx = (num > 4'd9) ? 4'd9 : num;
                2'd1: st_nx = (num > 4'd5) ? 4'd5 : num;
                2'd2: mo_nx = (num > 4'd9) ? 4'd9 : num;
                default: mt_nx = (num > MT_MAX) ? MT_MAX : num;
            endcase
        end
    end

    // State, prescaler, digits and registered flags. running is registered
    // from the next state so it always matches the current state.
    always_ff @(posedge clk_c or posedge reset_c) begin
        if (reset_c) begin
            state    <= IDLE;
            pause_q  <= 1'b0;
            presc    <= 16'd0;
            sec_ones <= 4'd0;
            sec_tens <= 4'd0;
            min_ones <= 4'd0;
            min_tens <= 4'd0;
            running  <= 1'b0;
            wrap     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            pause_q  <= pause_c;
            if (state != RUN || presc == PRE_LAST) begin
                presc <= 16'd0;
            end else begin
                presc <= presc + 16'd1;
            end
            sec_ones <= so_nx;
            sec_tens <= st_nx;
            min_ones <= mo_nx;
            min_tens <= mt_nx;
            running  <= (state_nx == RUN);
            wrap     <= wrap_nx;
            done     <= done_nx;
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core
// Self-checking bench for stopwatch_core (TICK_DIV=3, MIN_TENS_MAX=5).
// The reference model tracks the count as a plain number of seconds and
// derives the BCD digits with division; directed scenarios add fixed
// expected values, then a randomized phase runs against the model.
module tb_stopwatch_core;

    localparam int TD   = 3;
    localparam int MTM  = 5;
    localparam int MAXT = (MTM * 10 + 9) * 60 + 59;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_ADJ  = 2;

    logic       clk_c = 1'b0;
    logic       reset_c = 1'b1;
    logic       pause_c = 1'b0;
    logic       adj = 1'b0;
    logic [1:0] sel = 2'd0;
    logic [3:0] num = 4'd0;
    logic       load = 1'b0;
    logic       dir = 1'b0;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       running;
    logic       wrap;
    logic       done;
    logic [15:0] dig;

    int compare_count = 0;
    int fail_count = 0;

    // Reference model state
    int m_mode = M_IDLE;
    int m_t = 0;
    int m_pre = 0;
    bit m_pq = 1'b0;
    bit m_done = 1'b0;
    bit m_wrap = 1'b0;

    stopwatch_core #(.TICK_DIV(TD), .MIN_TENS_MAX(MTM)) dut (
        .clk_c(clk_c),
        .reset_c(reset_c),
        .pause_c(pause_c),
        .adj(adj),
        .sel(sel),
        .num(num),
        .load(load),
        .dir(dir),
        .sec_ones(sec_ones),
        .sec_tens(sec_tens),
        .min_ones(min_ones),
        .min_tens(min_tens),
        .running(running),
        .wrap(wrap),
        .done(done)
    );

    assign dig = {min_tens, min_ones, sec_tens, sec_ones};

    always #5 clk_c = ~clk_c;

    function automatic logic [15:0] expDig(int t);
        return {4'(t / 600), 4'((t / 60) % 10), 4'((t % 60) / 10), 4'(t % 10)};
    endfunction

    task automatic checkOutput(string tag, int got, int exp);
        compare_count++;
        if (got != exp) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic checkAll(string tag);
        checkOutput({tag, ".digits"}, dig, expDig(m_t));
        checkOutput({tag, ".running"}, running, (m_mode == M_RUN));
        checkOutput({tag, ".wrap"}, wrap, m_wrap);
        checkOutput({tag, ".done"}, done, m_done);
    endtask

    task automatic modelReset();
        m_mode = M_IDLE;
        m_t = 0;
        m_pre = 0;
        m_pq = 1'b0;
        m_done = 1'b0;
        m_wrap = 1'b0;
    endtask

    // One clock edge of the stopwatch, in terms of seconds elapsed.
    task automatic modelStep(bit p, bit a, int s, int n, bit l, bit d);
        bit pe;
        bit step_now;
        int old_mode;
        int dg[4];
        int lim[4];
        pe = p && !m_pq;
        m_pq = p;
        old_mode = m_mode;
        step_now = (m_mode == M_RUN) && (m_pre == TD - 1) && !a;
        m_pre = (m_mode == M_RUN && m_pre != TD - 1) ? m_pre + 1 : 0;
        m_wrap = 1'b0;
        if (step_now) begin
            if (!d) begin
                if (m_t == MAXT) begin
                    m_t = 0;
                    m_wrap = 1'b1;
                end else begin
                    m_t++;
                end
            end else if (m_t > 0) begin
                m_t--;
            end
        end
        if (a) begin
            m_mode = M_ADJ;
        end else if (old_mode == M_ADJ) begin
            m_mode = M_IDLE;
        end else if (old_mode == M_IDLE) begin
            if (pe && !(d && m_t == 0)) begin
                m_mode = M_RUN;
                m_done = 1'b0;
            end
        end else begin
            if (step_now && d && m_t == 0) begin
                m_done = 1'b1;
                m_mode = M_IDLE;
            end
            if (pe) m_mode = M_IDLE;
        end
        if (old_mode == M_ADJ && l) begin
            dg[0] = m_t % 10;
            dg[1] = (m_t % 60) / 10;
            dg[2] = (m_t / 60) % 10;
            dg[3] = m_t / 600;
            lim[0] = 9; lim[1] = 5; lim[2] = 9; lim[3] = MTM;
            dg[s] = (n > lim[s]) ? lim[s] : n;
            m_t = (dg[3] * 10 + dg[2]) * 60 + dg[1] * 10 + dg[0];
            m_done = 1'b0;
        end
    endtask

    // Drive one cycle of inputs, advance DUT and model, compare.
    task automatic applyStimulus(bit p, bit a, int s, int n, bit l, bit d, string tag);
        pause_c = p;
        adj = a;
        sel = 2'(s);
        num = 4'(n);
        load = l;
        dir = d;
        @(posedge clk_c);
        modelStep(p, a, s, n, l, d);
        #1;
        checkAll(tag);
    endtask

    // Assert reset between edges, check it acts at once, release on a negedge.
    task automatic doReset(string tag);
        #2;
        reset_c = 1'b1;
        modelReset();
        #1;
        checkAll(tag);
        repeat (2) @(posedge clk_c);
        #1;
        checkAll({tag, ".held"});
        @(negedge clk_c);
        reset_c = 1'b0;
    endtask

    initial begin
        bit p;
        bit a;
        bit d;
        logic [15:0] frozen;

        repeat (2) @(posedge clk_c);
        #1;
        checkAll("reset");
        @(negedge clk_c);
        reset_c = 1'b0;

        // Up count with a 3-cycle prescaler.
        applyStimulus(1, 0, 0, 0, 0, 0, "start");
        checkOutput("start.running", running, 1);
        for (int k = 1; k <= 30; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, "upcount");
            if (k == 27) checkOutput("upcount.0009", dig, 16'h0009);
            if (k == 30) checkOutput("upcount.0010", dig, 16'h0010);
        end

        // Rollover from 59:59.
        applyStimulus(0, 1, 0, 0, 0, 0, "adj_enter");
        applyStimulus(0, 1, 3, 5, 1, 0, "ld");
        applyStimulus(0, 1, 2, 9, 1, 0, "ld");
        applyStimulus(0, 1, 1, 5, 1, 0, "ld");
        applyStimulus(0, 1, 0, 8, 1, 0, "ld");
        checkOutput("load.5958", dig, 16'h5958);
        applyStimulus(0, 0, 0, 0, 0, 0, "adj_exit");
        applyStimulus(1, 0, 0, 0, 0, 0, "start2");
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, "wrap");
            if (k == 3) checkOutput("wrap.5959", dig, 16'h5959);
            if (k == 6) begin
                checkOutput("wrap.0000", dig, 16'h0000);
                checkOutput("wrap.pulse", wrap, 1);
                checkOutput("wrap.running", running, 1);
            end
            if (k == 7) checkOutput("wrap.single", wrap, 0);
        end

        // Down count from 01:00 to done.
        applyStimulus(0, 1, 0, 0, 0, 1, "adj_enter");
        applyStimulus(0, 1, 2, 1, 1, 1, "ld");
        applyStimulus(0, 1, 0, 0, 1, 1, "ld");
        checkOutput("load.0100", dig, 16'h0100);
        applyStimulus(0, 0, 0, 0, 0, 1, "adj_exit");
        applyStimulus(1, 0, 0, 0, 0, 1, "start3");
        for (int k = 1; k <= 183; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 1, "down");
            if (k == 3) checkOutput("down.0059", dig, 16'h0059);
        end
        checkOutput("down.zero", dig, 16'h0000);
        checkOutput("down.done", done, 1);
        checkOutput("down.stopped", running, 0);
        applyStimulus(1, 0, 0, 0, 0, 1, "zero_start");
        checkOutput("zero_start.running", running, 0);
        applyStimulus(0, 0, 0, 0, 0, 1, "zero_start2");
        checkOutput("zero_start2.running", running, 0);

        // Clamping in adjust mode; load is ignored before ADJ is reached.
        applyStimulus(0, 1, 1, 9, 1, 0, "clamp_pre");
        checkOutput("clamp_pre.ignored", dig, 16'h0000);
        checkOutput("clamp_pre.done", done, 1);
        applyStimulus(0, 1, 1, 9, 1, 0, "clamp");
        checkOutput("clamp.sec_tens", dig, 16'h0050);
        checkOutput("clamp.done_clr", done, 0);
        applyStimulus(0, 1, 3, 7, 1, 0, "clamp");
        checkOutput("clamp.min_tens", dig, 16'h5050);
        applyStimulus(0, 0, 0, 0, 0, 0, "clamp_exit");
        checkOutput("clamp_exit.running", running, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, "clamp_start");
        checkOutput("clamp_start.running", running, 1);

        // Back to IDLE, then hold pause_c high: a single transition to RUN.
        applyStimulus(0, 0, 0, 0, 0, 0, "pause_lo");
        applyStimulus(1, 0, 0, 0, 0, 0, "pause");
        checkOutput("pause.running", running, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, "pause_lo2");
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, "hold");
            checkOutput("hold.running", running, 1);
        end
        frozen = expDig(m_t);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, 0, 0, 0, 0, "freeze");
            checkOutput("freeze.digits", dig, frozen);
            checkOutput("freeze.running", running, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 0, "freeze_exit");

        // Reset in the middle of a count at 12:34.
        applyStimulus(0, 1, 0, 0, 0, 0, "adj_enter");
        applyStimulus(0, 1, 3, 1, 1, 0, "ld");
        applyStimulus(0, 1, 2, 2, 1, 0, "ld");
        applyStimulus(0, 1, 1, 3, 1, 0, "ld");
        applyStimulus(0, 1, 0, 4, 1, 0, "ld");
        checkOutput("load.1234", dig, 16'h1234);
        applyStimulus(0, 0, 0, 0, 0, 0, "adj_exit");
        applyStimulus(1, 0, 0, 0, 0, 0, "start4");
        applyStimulus(0, 0, 0, 0, 0, 0, "midrun");
        doReset("midreset");
        checkOutput("midreset.digits", dig, 16'h0000);
        checkOutput("midreset.running", running, 0);
        checkOutput("midreset.done", done, 0);

        // Randomized phase against the model.
        p = 1'b0;
        a = 1'b0;
        d = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 5) == 0) p = ~p;
            if ($urandom_range(0, 19) == 0) a = ~a;
            if ($urandom_range(0, 39) == 0) d = ~d;
            applyStimulus(p, a, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                          bit'($urandom_range(0, 1)), d, "random");
            if ($urandom_range(0, 499) == 0) doReset("random_reset");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
        $finish;
    end

endmodule
